bcd_pow2_seq: RTL and testbench
===============================

// Module: bcd_pow2_seq
// PURPOSE
//   Sequencer that multiplies a packed-BCD operand by 2^k by applying the per-digit BCD
//   doubling datapath k times, one doubling per clock. Accepts a start request, runs k
//   iterations, then presents the wrapped BCD result with an overflow flag and a done pulse.
//   Sits between a requester (console/test logic) and the BCD doubling datapath.
// PARAMETERS
//   DIGITS  3  number of BCD digits in operand/result (data width = 4*DIGITS)
//   CNT_W   4  width of iteration count; k ranges 0 .. 2^CNT_W-1
// PORTS
//   clk        in   1         single clock; all state changes on rising edge
//   rst        in   1         reset, synchronous, active-high
//   start      in   1         request; sampled only when ready=1
//   bcd_in     in   4*DIGITS  operand, packed BCD, digit 0 in [3:0]
//   shift_cnt  in   CNT_W     k = number of doublings
//   ready      out  1         1 when a start will be accepted (state IDLE or DONE)
//   done       out  1         one-cycle pulse: bcd_out/overflow valid for this operation
//   bcd_out    out  4*DIGITS  result = (bcd_in * 2^k) mod 10^DIGITS, packed BCD
//   overflow   out  1         1 if any doubling carried out of the top digit
//   err        out  1         invalid-digit flag (see CONFIGURATION); 0 otherwise
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, acc=0, cnt=0, bcd_out=0, overflow=0, done=0, err=0, ready=1.
//     rst mid-RUN aborts the operation; no done pulse; outputs return to reset values.
//   States: IDLE, RUN, DONE. ready = (state!=RUN); done = (state==DONE).
//   IDLE/DONE + start: load acc<=bcd_in, cnt<=shift_cnt, overflow<=0, err<=0;
//     next = RUN if shift_cnt!=0 else DONE. DONE without start -> IDLE.
//   RUN: each edge acc<=double(acc), cnt<=cnt-1, overflow<=overflow|carry_out;
//     when cnt==1 at that edge -> DONE. start ignored (not queued) while in RUN.
//   Latency: done high in the (k+1)th cycle after the start-sampling edge; k=0 -> next cycle.
//   Throughput: start accepted in DONE cycle -> back-to-back ops, one idle-free cycle apart.
//   double(): per digit d, s=2*d+cin; if s>=10 then out=s-10, cout=1 else out=s, cout=0;
//     cin of digit 0 is 0; carry_out = cout of digit DIGITS-1. Result wraps mod 10^DIGITS.
//   bcd_out mirrors acc; holds last result until the next accepted start reloads acc.
//   overflow sticky across all k iterations of one op; cleared only on load or reset.
//   Non-BCD input digits (>9) without macro: undefined result; no check performed.
// CONFIGURATION
//   BCD_INPUT_CHECK_EN defined: on accepted start, if any bcd_in digit >9, acc<=0,
//     err<=1, overflow<=0, next=DONE regardless of shift_cnt (done pulse next cycle).
//   Not defined: no check logic; err tied to 0.
// STRUCTURE
//   Shared package bcd_pkg: BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9, state encoding
//     (IDLE=2'd0, RUN=2'd1, DONE=2'd2), function is_bcd_digit().
//   One sub-module: bcd_digit_double (4-bit digit + carry in -> 4-bit digit + carry out),
//     instantiated DIGITS times in a carry chain via generate; FSM/counter in this module.
// TESTING
//   1) rst=1 2 cycles, then start bcd_in=12'h499 k=1 -> done after 2 cycles, bcd_out=12'h998, ovf=0.
//   2) bcd_in=12'h500 k=1 -> bcd_out=12'h000, overflow=1; bcd_in=12'h123 k=3 -> 12'h984, ovf=0.
//   3) bcd_in=12'h001 k=9 -> 12'h512, ovf=0 at cycle 10; k=10 -> 12'h024, ovf=1 at cycle 11.
//   4) k=0, bcd_in=12'h377 -> done next cycle, bcd_out=12'h377; start held during RUN ignored,
//      start asserted in DONE cycle accepted (back-to-back, ready low only during RUN).
//   5) start 12'h125 k=4, assert rst at 2nd RUN cycle -> no done, outputs 0, ready=1 next cycle;
//      rerun -> bcd_out=12'h000, overflow=1 (2000 wraps).
//   6) BCD_INPUT_CHECK_EN: bcd_in=12'h1A3 k=5 -> done next cycle, err=1, bcd_out=0;
//      without macro, err stays 0 for every case.
//   Bench sweeps all legal 3-digit operands x k=0..4 against a reference model (x*2^k mod 1000).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit, sequencer state encoding.
// Pure declarations, no logic and no latency.
// Used by bcd_pow2_seq and bcd_digit_double; optional input check is BCD_INPUT_CHECK_EN.
package bcd_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a nibble holds a legal decimal digit (0..9)
  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_double.sv
// One BCD digit doubler: out = (2*d + cin) mod 10, cout set when the sum reaches 10.
// Purely combinational, zero latency.
// No handshake; a chain of these forms the per-clock doubling datapath.
module bcd_digit_double
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   cout
);

  logic [BCD_DIGIT_W:0] s;

  // Double the digit, add incoming carry, then decimal-correct
  always_comb begin
    s = {d, 1'b0} + {{BCD_DIGIT_W{1'b0}}, cin};
    if (s >= (BCD_DIGIT_W+1)'(10)) begin
      q    = BCD_DIGIT_W'(s - (BCD_DIGIT_W+1)'(10));
      cout = 1'b1;
    end else begin
      q    = s[BCD_DIGIT_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_pow2_seq.sv
// Multiplies a packed-BCD operand by 2^k, one BCD doubling per clock (macro: BCD_INPUT_CHECK_EN).
// Latency: done is high k+1 cycles after the start-sampling edge (k=0 -> next cycle).
// Backpressure: ready is low only while running; start outside ready is dropped, not queued.
module bcd_pow2_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic [CNT_W-1:0]              shift_cnt,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow,
  output logic                          err
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     acc_dbl;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             err_q;
  logic [DIGITS:0]  carry;
  logic             bad_in;
  logic             accept;

  // Ripple carry chain of digit doublers; digit 0 has no incoming carry
  assign carry[0] = 1'b0;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dbl
    bcd_digit_double u_dbl (
      .d    (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cin  (carry[g]),
      .q    (acc_dbl[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .cout (carry[g+1])
    );
  end

`ifdef BCD_INPUT_CHECK_EN
  // Flag an operand containing any nibble above 9
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_in = 1'b1;
    end
  end
`else
  assign bad_in = 1'b0;
`endif

  assign accept = start && ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a load skips RUN when there is nothing to do or the operand is rejected
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (bad_in || shift_cnt == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = (bad_in || shift_cnt == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    ready = (state_q != RUN);
    done  = (state_q == DONE);
  end

  // Accumulator, iteration counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      acc_q <= bad_in ? '0 : bcd_in;
      cnt_q <= shift_cnt;
      ovf_q <= 1'b0;
      err_q <= bad_in;
    end else if (state_q == RUN) begin
      acc_q <= acc_dbl;
      cnt_q <= cnt_q - CNT_W'(1);
      ovf_q <= ovf_q | carry[DIGITS];
    end
  end

  assign bcd_out  = acc_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_pow2_seq.sv
// Directed and sweep checks for bcd_pow2_seq against an arithmetic reference model.
// Expectations are queued at start and compared when done rises.
// Every wait for done is bounded by a cycle budget.
module tb_bcd_pow2_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic [3:0]  shift_cnt;
  logic        ready;
  logic        done;
  logic [11:0] bcd_out;
  logic        overflow;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bcd_pow2_seq #(.DIGITS(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .shift_cnt (shift_cnt),
    .ready     (ready),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Reference: repeated decimal doubling, overflow when any step reaches 1000
  function automatic exp_t model(input logic [11:0] b, input int k);
    exp_t e;
    int v;
    v     = bcd2int(b);
    e.ovf = 1'b0;
    e.err = 1'b0;
    for (int i = 0; i < k; i++) begin
      v = v * 2;
      if (v >= 1000) begin
        v     = v - 1000;
        e.ovf = 1'b1;
      end
    end
    e.bcd = int2bcd(v);
    e.lat = k + 1;
    return e;
  endfunction

  // Drive a start at the current (falling) edge, queue the expectation, wait for done.
  // hold keeps start asserted with junk data through RUN to show it is ignored.
  task automatic issue(input logic [11:0] b, input int k, input bit hold);
    exp_t e;
    exp_t got;
    int   cyc;
    check("ready_before_start", ready, 1'b1);
    e = model(b, k);
    sb_q.push_back(e);
    start     = 1'b1;
    bcd_in    = b;
    shift_cnt = 4'(k);
    @(negedge clk);
    cyc = 1;
    if (hold) begin
      bcd_in    = 12'h777;
      shift_cnt = 4'd2;
    end else begin
      start = 1'b0;
    end
    while (!done && cyc < 40) begin
      check("ready_low_in_run", ready, 1'b0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 32'(cyc), 32'(e.lat));
      void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      check("done_without_expectation", 1'b1, 1'b0);
    end else begin
      got = sb_q.pop_front();
      check("latency", 32'(cyc), 32'(got.lat));
      check("bcd_out", bcd_out, got.bcd);
      check("overflow", overflow, got.ovf);
      check("err", err, got.err);
    end
  endtask

  task automatic run_op(input logic [11:0] b, input int k);
    @(negedge clk);
    issue(b, k, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bcd_in    = '0;
    shift_cnt = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_bcd_out", bcd_out, 12'h000);
    check("rst_overflow", overflow, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Directed operands from the block description
    run_op(12'h499, 1);
    run_op(12'h500, 1);
    run_op(12'h123, 3);
    run_op(12'h001, 9);
    run_op(12'h001, 10);
    run_op(12'h999, 15);
    run_op(12'h377, 0);

    // Result holds after done until the next load
    @(negedge clk);
    check("hold_done_low", done, 1'b0);
    check("hold_bcd_out", bcd_out, 12'h377);

    // start held during RUN is ignored; start in the DONE cycle is accepted back-to-back
    @(negedge clk);
    issue(12'h123, 3, 1'b1);
    issue(12'h250, 2, 1'b0);
    issue(12'h042, 0, 1'b0);
    issue(12'h300, 2, 1'b0);

    // Reset in the second RUN cycle aborts the op
    @(negedge clk);
    check("abort_ready_idle", ready, 1'b1);
    start     = 1'b1;
    bcd_in    = 12'h125;
    shift_cnt = 4'd4;
    @(negedge clk);
    start = 1'b0;
    check("abort_run1_ready", ready, 1'b0);
    @(negedge clk);
    check("abort_run2_done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", done, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_bcd_out", bcd_out, 12'h000);
    check("abort_overflow", overflow, 1'b0);
    @(negedge clk);
    check("abort_no_late_done", done, 1'b0);
    run_op(12'h125, 4);

`ifdef BCD_INPUT_CHECK_EN
    // Invalid digit: rejected at load, done next cycle, err set, result cleared
    begin
      exp_t e;
      @(negedge clk);
      e.bcd = 12'h000;
      e.ovf = 1'b0;
      e.err = 1'b1;
      e.lat = 1;
      sb_q.push_back(e);
      start     = 1'b1;
      bcd_in    = 12'h1A3;
      shift_cnt = 4'd5;
      @(negedge clk);
      start = 1'b0;
      check("inv_done", done, 1'b1);
      e = sb_q.pop_front();
      check("inv_bcd_out", bcd_out, e.bcd);
      check("inv_err", err, e.err);
      check("inv_overflow", overflow, e.ovf);
    end
    run_op(12'h123, 1);
`endif

    // Sweep every legal operand for k = 0..4
    for (int x = 0; x < 1000; x++) begin
      for (int k = 0; k <= 4; k++) begin
        run_op(int2bcd(x), k);
      end
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
